// File: rtl/counter_4bit_pkg.sv
// Shared widths, types and constants for the counter_4bit slice.
package counter_4bit_pkg;

  localparam int unsigned CNT_W = 4;

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t CNT_MAX = '1;
  localparam cnt_t CNT_RST = '0;

endpackage : counter_4bit_pkg

// File: rtl/counter_4bit_if.sv
// Load request and counter status bundle between a controller and counter_4bit.
interface counter_4bit_if
  import counter_4bit_pkg::*;
#(
  parameter int unsigned WIDTH = CNT_W
);

  logic             load;
  logic [WIDTH-1:0] load_data;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             wrap;

  modport master (
    output load,
    output load_data,
    input  count,
    input  tc,
    input  wrap
  );

  modport slave (
    input  load,
    input  load_data,
    output count,
    output tc,
    output wrap
  );

endinterface : counter_4bit_if

// File: rtl/counter_4bit_next.sv
// Next-state logic: load beats increment; increment wraps, or saturates when
// COUNTER_4BIT_SATURATE_EN is defined.
module counter_4bit_next
  import counter_4bit_pkg::*;
#(
  parameter int unsigned WIDTH = CNT_W
) (
  input  logic [WIDTH-1:0] cur,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] nxt,
  output logic             wrap_nxt
);

  localparam logic [WIDTH-1:0] MAX_VAL = '1;

  logic [WIDTH:0] sum;

  assign sum = (WIDTH+1)'(cur) + (WIDTH+1)'(1);

  // load_data only reaches nxt through the load branch, so X on it stays contained
  always_comb begin
    nxt      = cur;
    wrap_nxt = 1'b0;
    if (load) begin
      nxt = load_data;
    end else begin
`ifdef COUNTER_4BIT_SATURATE_EN
      if (cur != MAX_VAL) begin
        nxt = sum[WIDTH-1:0];
      end
`else
      nxt      = sum[WIDTH-1:0];
      wrap_nxt = sum[WIDTH];
`endif
    end
  end

`ifdef COUNTER_4BIT_SATURATE_EN
`else
  logic unused_max;
  assign unused_max = ^MAX_VAL;
`endif

endmodule : counter_4bit_next

// File: rtl/counter_4bit.sv
// 4-bit up-counter with parallel load, terminal-count flag and wrap pulse.
// Optional build macro: COUNTER_4BIT_SATURATE_EN (saturate at max instead of wrapping).
module counter_4bit
  import counter_4bit_pkg::*;
#(
  parameter int unsigned      WIDTH     = CNT_W,
  parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(CNT_RST)
) (
  input  logic           clk,
  input  logic           reset_n,
  counter_4bit_if.slave  bus
);

  localparam logic [WIDTH-1:0] MAX_VAL = '1;

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_nxt;
  logic             wrap_q;
  logic             wrap_nxt;

  counter_4bit_next #(
    .WIDTH (WIDTH)
  ) u_next (
    .cur       (count_q),
    .load      (bus.load),
    .load_data (bus.load_data),
    .nxt       (count_nxt),
    .wrap_nxt  (wrap_nxt)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= RESET_VAL;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_nxt;
      wrap_q  <= wrap_nxt;
    end
  end

  assign bus.count = count_q;
  assign bus.wrap  = wrap_q;
  // Terminal count is decoded straight from the register
  assign bus.tc    = (count_q == MAX_VAL);

endmodule : counter_4bit

// File: tb/tb_counter_4bit.sv
// Self-checking bench for counter_4bit: directed vector table, reset corner, random run vs model.
module tb_counter_4bit;

  logic clk;
  logic reset_n;
  int   total;
  int   bad;

  counter_4bit_if #(.WIDTH(4)) bus ();

  counter_4bit #(
    .WIDTH     (4),
    .RESET_VAL (4'h0)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       ld;
    logic [3:0] d;
    logic [3:0] c;
    logic       t;
    logic       w;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string name, input int c, input int t, input int w);
    check({name, ".count"}, 8'(bus.count), 8'(c));
    check({name, ".tc"},    8'(bus.tc),    8'(t));
    check({name, ".wrap"},  8'(bus.wrap),  8'(w));
  endtask

  // Inputs change 1 time unit after an edge; outputs are checked at the same point
  task automatic step(input logic ld, input logic [3:0] d);
    bus.load      = ld;
    bus.load_data = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int m;
    int mw;
    logic       ld;
    logic [3:0] d;
    total = 0;
    bad   = 0;

    reset_n       = 1'b0;
    bus.load      = 1'b0;
    bus.load_data = 4'h0;
    #12;
    check_outs("reset_initial", 0, 0, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Run to 7, then reset asynchronously in the middle of a cycle
    step(1'b1, 4'h4);
    step(1'b0, 4'hx);
    step(1'b0, 4'hx);
    step(1'b0, 4'hx);
    check_outs("pre_reset", 7, 0, 0);
    #2;
    reset_n = 1'b0;
    #1;
    check_outs("reset_async", 0, 0, 0);
    @(posedge clk);
    #1;
    check_outs("reset_held", 0, 0, 0);
    reset_n = 1'b1;

`ifdef COUNTER_4BIT_SATURATE_EN
    vecs.push_back('{1'b1, 4'hD, 4'hD, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 4'h0, 4'hE, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 4'h0, 4'hF, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 4'h0, 4'hF, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 4'h0, 4'hF, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 4'h9, 4'h9, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 4'h2, 4'h2, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 4'h5, 4'h5, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 4'hA, 4'hA, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 4'h0, 4'hB, 1'b0, 1'b0});
`else
    vecs.push_back('{1'b1, 4'h2, 4'h2, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 4'h0, 4'h3, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 4'h0, 4'h4, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 4'h0, 4'h5, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 4'hE, 4'hE, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 4'h0, 4'hF, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 4'h0, 4'h0, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 4'h0, 4'h1, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 4'hF, 4'hF, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 4'h9, 4'h9, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 4'h2, 4'h2, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 4'h5, 4'h5, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 4'hA, 4'hA, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 4'hF, 4'hF, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 4'h0, 4'h0, 1'b0, 1'b1});
    vecs.push_back('{1'b1, 4'h3, 4'h3, 1'b0, 1'b0});
`endif

    foreach (vecs[i]) begin
      step(vecs[i].ld, vecs[i].d);
      check_outs($sformatf("vec%0d", i), int'(vecs[i].c), int'(vecs[i].t), int'(vecs[i].w));
    end

    // Random run against an arithmetic model; starts from a known load
    step(1'b1, 4'h0);
    m  = 0;
    mw = 0;
    check_outs("rand_start", m, 0, mw);
    for (int k = 0; k < 400; k++) begin
      ld = ($urandom_range(3) == 0);
      d  = 4'($urandom_range(15));
      step(ld, d);
      if (ld) begin
        m  = int'(d);
        mw = 0;
      end else begin
`ifdef COUNTER_4BIT_SATURATE_EN
        mw = 0;
        if (m < 15) m = m + 1;
`else
        mw = (m == 15) ? 1 : 0;
        m  = (m + 1) % 16;
`endif
      end
      check_outs($sformatf("rand%0d", k), m, (m == 15) ? 1 : 0, mw);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_counter_4bit

// File: doc/counter_4bit.md
Name: counter_4bit

Overview:
- Synchronous 4-bit up-counter with parallel load.
- Used as a general-purpose event/cycle counter and as a small preset-able timer.
- Loads `load_data` on request; otherwise increments every clock and wraps modulo 16.
- Provides a terminal-count flag and a one-cycle wrap pulse for cascading.

Parameters:
- WIDTH, 4, counter width in bits. Only 4 is verified; RTL is written width-generic.
- RESET_VAL, 4'h0, value forced onto `count` during reset.

Ports:
- clk  input  1  rising-edge clock; all state updates on posedge.
- reset_n  input  1  asynchronous active-low reset.
- load  input  1  synchronous parallel-load request, active high.
- load_data  input  WIDTH  value loaded when `load`=1.
- count  output  WIDTH  current counter value, registered.
- tc  output  1  terminal count, combinational: 1 when `count` == 2^WIDTH-1.
- wrap  output  1  registered one-cycle pulse, asserted in the cycle after `count` rolled from max to 0 by increment.

Behaviour:
- Reset: `reset_n`=0 asynchronously forces `count`=RESET_VAL and `wrap`=0. `tc` follows `count`, so it is 0 for the default RESET_VAL.
- Reset release is synchronous to clk: the first update occurs on the first posedge after `reset_n` rises.
- Reset mid-operation aborts immediately, with no pending load or increment retained.
- Per posedge with `reset_n`=1, priority is load > increment:
  - `load`=1: `count` <= `load_data`; `wrap` <= 0.
  - `load`=0: `count` <= `count`+1 mod 2^WIDTH; `wrap` <= 1 only if the old `count` was 2^WIDTH-1, else 0.
- Latency:
  - A load is visible on `count` one cycle after the sampling edge.
  - No enable exists; the counter advances every non-load cycle.
- Loading 4'hF:
  - `tc`=1 the next cycle.
  - The following increment gives 0 with `wrap`=1.
- Loading while `count`=F: the load wins, `count`=`load_data`, and no wrap pulse.
- `load` held high for multiple cycles keeps reloading, so `count` stays at `load_data`, tracking changes with one-cycle latency.
- Arithmetic is unsigned; the carry out of the MSB is discarded except for generating `wrap`.
- No X propagation from `load_data` when `load`=0.

Optional Feature:
- Macro: COUNTER_4BIT_SATURATE_EN.
- Defined: the increment saturates at 2^WIDTH-1.
  - `count` holds at F while `load`=0.
  - `wrap` is never asserted (tied 0).
  - `tc` is unchanged.
  - Load still overrides.
- Undefined (default): modulo-2^WIDTH wrap-around as described above.

Decomposition:
- Package `counter_4bit_pkg`:
  - localparam CNT_W=4.
  - typedef logic [CNT_W-1:0] cnt_t.
  - localparam cnt_t CNT_MAX='1.
  - localparam cnt_t CNT_RST='0.
- One natural combinational sub-module, `counter_4bit_next`:
  - Inputs: cur, load, load_data.
  - Outputs: nxt, wrap_nxt.
  - Holds the priority and saturate/wrap logic.
- The top holds only the async-reset registers and the `tc` compare.

Test Plan:
- Reset: assert `reset_n`=0 mid-count with `count`=7 -> `count`=0, `wrap`=0, `tc`=0 immediately without waiting for a clock edge; stays 0 while low.
- Load: release reset, `load`=1, `load_data`=4'h2 for one edge -> `count`=2; drop `load` -> 3, 4, 5 on successive edges.
- Wrap: load 4'hE, then free-run -> E, F (`tc`=1), 0 (`wrap`=1 for exactly one cycle), 1 (`wrap`=0).
- Load priority at max: `count`=F with `load`=1, `load_data`=4'h9 -> `count`=9, `wrap`=0.
- Held load: `load`=1 for 3 edges with `load_data` changing 2→5→A -> `count` follows 2, 5, A with one-cycle latency.
- Saturate build (COUNTER_4BIT_SATURATE_EN): load D, free-run 5 cycles -> D, E, F, F, F; `wrap` always 0; `tc`=1 from the first F.
